// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 256-byte data memory.
// Serves one latched request at a time, holds the strobes for ACC_CYC cycles, then acks.
module dmem_arbiter #(
  parameter int ACC_CYC   = 2,
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_word,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_word,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        m1_err,
  output logic        gnt_id,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        mem_word_en,
  output logic        mem_ld_en,
  output logic        mem_write,
  output logic        mem_read,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  // state  | meaning
  // IDLE   | waiting for a request; arbitrates and latches the winner
  // ACCESS | memory strobes held, counter running down to capture
  // DONE   | one-cycle ack (with err) to the granted port
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [16:0] MEM_LIM  = 17'(MEM_BYTES);
  localparam logic [3:0]  CNT_INIT = 4'(ACC_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, word_q, err_q, gnt_q, last_q;
  logic [15:0] addr_q, wdata_q, rdata0_q, rdata1_q;

  logic        sel, sel_we, sel_word, range_err, latch, capture;
  logic [15:0] sel_addr, sel_wdata;

  // Round-robin on a tie: the port not granted last wins.
  assign sel       = (m0_req && m1_req) ? ~last_q : m1_req;
  assign sel_we    = sel ? m1_we    : m0_we;
  assign sel_word  = sel ? m1_word  : m0_word;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign range_err = ({1'b0, sel_addr} >= MEM_LIM) ||
                     (sel_word && ({1'b0, sel_addr} == (MEM_LIM - 17'd1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          latch   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = range_err ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      word_q   <= 1'b0;
      err_q    <= 1'b0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (latch) begin
        we_q    <= sel_we;
        word_q  <= sel_word;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        gnt_q   <= sel;
        last_q  <= sel;
        err_q   <= range_err;
        // A rejected access returns zero data rather than stale data.
        if (range_err) begin
          if (sel) rdata1_q <= '0;
          else     rdata0_q <= '0;
        end
      end
      if (capture) begin
        if (gnt_q) rdata1_q <= mem_rdata;
        else       rdata0_q <= mem_rdata;
      end
    end
  end

  logic acc, done;
  assign acc  = (state_q == ACCESS);
  assign done = (state_q == DONE);

  assign mem_addr    = addr_q;
  assign mem_write   = acc &  we_q;
  assign mem_read    = acc & ~we_q;
  assign mem_word_en = acc &  we_q & word_q;
  assign mem_ld_en   = acc & ~we_q & word_q;
  // Byte stores replicate the byte so either memory lane receives it.
  assign mem_wdata   = !mem_write ? 16'h0000 :
                       (word_q ? wdata_q : {wdata_q[7:0], wdata_q[7:0]});

  assign m0_ack   = done & ~gnt_q;
  assign m1_ack   = done &  gnt_q;
  assign m0_err   = m0_ack & err_q;
  assign m1_err   = m1_ack & err_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign gnt_id   = gnt_q;
  assign busy     = acc | done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed memory model
// (little-endian words, sign-extending byte loads).
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        m0_req, m0_we, m0_word, m1_req, m1_we, m1_word;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err, gnt_id, busy;
  logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_word_en, mem_ld_en, mem_write, mem_read;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ACC_CYC(2), .MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_word(m0_word), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_word(m1_word), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .gnt_id(gnt_id), .busy(busy), .mem_addr(mem_addr), .mem_word_en(mem_word_en),
    .mem_ld_en(mem_ld_en), .mem_write(mem_write), .mem_read(mem_read),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] ma, ma1;
  assign ma  = mem_addr[7:0];
  assign ma1 = ma + 8'd1;

  always @(posedge clk) begin
    if (mem_write) begin
      if (mem_word_en) begin
        mem[ma]  <= mem_wdata[7:0];
        mem[ma1] <= mem_wdata[15:8];
      end else begin
        mem[ma]  <= mem_wdata[7:0];
      end
    end
  end

  always_comb begin
    if (mem_ld_en) mem_rdata = {mem[ma1], mem[ma]};
    else           mem_rdata = {{8{mem[ma][7]}}, mem[ma]};
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set0(input logic we, input logic word, input logic [15:0] a, input logic [15:0] d);
    m0_we = we; m0_word = word; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
  endtask

  task automatic set1(input logic we, input logic word, input logic [15:0] a, input logic [15:0] d);
    m1_we = we; m1_word = word; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
  endtask

  // Invariants checked every cycle.
  always @(negedge clk) begin
    chk1("rw_exclusive", mem_write & mem_read, 1'b0);
    chk1("strobe_idle", ~busy & (mem_write | mem_read | mem_word_en | mem_ld_en), 1'b0);
  end

  logic exp_g [4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_word = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_word = 0; m1_addr = '0; m1_wdata = '0;
    cyc(); cyc();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_gnt", gnt_id, 1'b0);
    chk16("rst_addr", mem_addr, 16'h0000);
    chk16("rst_rdata0", m0_rdata, 16'h0000);
    chk1("rst_ack", m0_ack | m1_ack, 1'b0);

    // m0 word store then back-to-back word load
    rst_n = 1'b1;
    set0(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    cyc();
    chk1("st_write", mem_write, 1'b1);
    chk1("st_word_en", mem_word_en, 1'b1);
    chk1("st_ld_en", mem_ld_en, 1'b0);
    chk16("st_addr", mem_addr, 16'h0010);
    chk16("st_wdata", mem_wdata, 16'hBEEF);
    chk1("st_gnt", gnt_id, 1'b0);
    cyc();
    chk1("st_write2", mem_write, 1'b1);
    chk1("st_ack_early", m0_ack, 1'b0);
    cyc();
    chk1("st_ack", m0_ack, 1'b1);
    chk1("st_write_off", mem_write, 1'b0);
    chk1("st_err", m0_err, 1'b0);
    chk16("st_addr_hold", mem_addr, 16'h0010);
    m0_we = 1'b0;
    cyc();
    chk1("b2b_idle_busy", busy, 1'b0);
    chk1("b2b_idle_ack", m0_ack, 1'b0);
    cyc();
    chk1("ld_read", mem_read, 1'b1);
    chk1("ld_ld_en", mem_ld_en, 1'b1);
    chk1("ld_word_en", mem_word_en, 1'b0);
    cyc(); cyc();
    chk1("ld_ack", m0_ack, 1'b1);
    chk16("ld_rdata", m0_rdata, 16'hBEEF);
    chk1("ld_err", m0_err, 1'b0);
    chk1("ld_m1_ack", m1_ack, 1'b0);
    m0_req = 1'b0;
    cyc();
    chk16("ld_rdata_hold", m0_rdata, 16'hBEEF);
    chk1("ld_ack_off", m0_ack, 1'b0);

    // m1 byte store then byte load
    set1(1'b1, 1'b0, 16'h0020, 16'h0081);
    cyc();
    chk16("bst_wdata", mem_wdata, 16'h8181);
    chk1("bst_write", mem_write, 1'b1);
    chk1("bst_word_en", mem_word_en, 1'b0);
    chk1("bst_gnt", gnt_id, 1'b1);
    cyc(); cyc();
    chk1("bst_ack", m1_ack, 1'b1);
    chk1("bst_m0_ack", m0_ack, 1'b0);
    m1_we = 1'b0;
    cyc(); cyc();
    chk1("bld_read", mem_read, 1'b1);
    chk1("bld_ld_en", mem_ld_en, 1'b0);
    cyc(); cyc();
    chk1("bld_ack", m1_ack, 1'b1);
    chk16("bld_rdata", m1_rdata, 16'hFF81);
    m1_req = 1'b0;
    cyc();

    // out-of-range accesses
    set0(1'b0, 1'b1, 16'h00FF, 16'h0000);
    cyc();
    chk1("oor0_ack", m0_ack, 1'b1);
    chk1("oor0_err", m0_err, 1'b1);
    chk16("oor0_rdata", m0_rdata, 16'h0000);
    chk1("oor0_read", mem_read, 1'b0);
    chk1("oor0_busy", busy, 1'b1);
    m0_req = 1'b0;
    cyc();
    chk1("oor0_ack_off", m0_ack, 1'b0);
    chk1("oor0_err_off", m0_err, 1'b0);
    set1(1'b0, 1'b0, 16'h0100, 16'h0000);
    cyc();
    chk1("oor1_ack", m1_ack, 1'b1);
    chk1("oor1_err", m1_err, 1'b1);
    chk16("oor1_rdata", m1_rdata, 16'h0000);
    chk1("oor1_read", mem_read, 1'b0);
    m1_req = 1'b0;
    cyc();
    set0(1'b0, 1'b0, 16'h00FF, 16'h0000);
    cyc();
    chk1("edge_byte_read", mem_read, 1'b1);
    chk1("edge_byte_ack_early", m0_ack, 1'b0);
    cyc(); cyc();
    chk1("edge_byte_ack", m0_ack, 1'b1);
    chk1("edge_byte_err", m0_err, 1'b0);
    m0_req = 1'b0;
    cyc();

    // m0 drops req one cycle into ACCESS
    set0(1'b0, 1'b1, 16'h0010, 16'h0000);
    cyc();
    chk1("drop_read", mem_read, 1'b1);
    m0_req = 1'b0;
    cyc(); cyc();
    chk1("drop_ack", m0_ack, 1'b1);
    chk16("drop_rdata", m0_rdata, 16'hBEEF);
    cyc();
    chk1("drop_idle1", busy, 1'b0);
    cyc();
    chk1("drop_idle2", busy, 1'b0);
    chk1("drop_no_read", mem_read, 1'b0);

    // reset during an m1 store
    set1(1'b1, 1'b1, 16'h0030, 16'h1234);
    cyc();
    chk1("rst_mid_write", mem_write, 1'b1);
    chk1("rst_mid_gnt", gnt_id, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_write_drop", mem_write, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    m1_req = 1'b0;
    cyc();
    chk1("rst_mid_no_ack1", m1_ack, 1'b0);
    cyc();
    chk1("rst_mid_no_ack2", m1_ack, 1'b0);

    // both ports request continuously from reset: grants alternate
    set0(1'b0, 1'b1, 16'h0010, 16'h0000);
    set1(1'b0, 1'b0, 16'h0020, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1($sformatf("rr%0d_gnt", i), gnt_id, exp_g[i]);
      cyc(); cyc();
      chk1($sformatf("rr%0d_m0_ack", i), m0_ack, ~exp_g[i]);
      chk1($sformatf("rr%0d_m1_ack", i), m1_ack, exp_g[i]);
      if (exp_g[i]) chk16($sformatf("rr%0d_m1_rdata", i), m1_rdata, 16'hFF81);
      else          chk16($sformatf("rr%0d_m0_rdata", i), m0_rdata, 16'hBEEF);
      if (i == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      cyc();
      chk1($sformatf("rr%0d_ack_off", i), m0_ack | m1_ack, 1'b0);
    end
    cyc();
    chk1("final_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
